// File: rtl/regfile_pkg.sv
// Shared definitions for the parametrised register file: function-select codes
// and the read-select width helper.
package regfile_pkg;

  localparam logic [2:0] FS_CLR  = 3'b000;
  localparam logic [2:0] FS_LOAD = 3'b001;
  localparam logic [2:0] FS_INC  = 3'b010;
  localparam logic [2:0] FS_DEC  = 3'b011;
  localparam logic [2:0] FS_SHL  = 3'b100;
  localparam logic [2:0] FS_SHR  = 3'b101;
  localparam logic [2:0] FS_ROL  = 3'b110;
  localparam logic [2:0] FS_HOLD = 3'b111;

  // A single-register file still needs a one-bit select port.
  function automatic int sel_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/reg_cell.sv
// One register of the file: applies the selected function when enabled and
// flags an inc-at-max or dec-at-zero event for the shared overflow flag.
module reg_cell
  import regfile_pkg::*;
#(
  parameter int          WIDTH     = 8,
  parameter bit          SATURATE  = 1'b0,
  parameter int unsigned RESET_VAL = 0
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             En,
  input  logic [2:0]       FunSel,
  input  logic [WIDTH-1:0] I,
  output logic [WIDTH-1:0] Q,
  output logic             OvfEvt
);

  localparam logic [WIDTH-1:0] RST_V = WIDTH'(RESET_VAL);
  localparam logic [WIDTH-1:0] ONES  = '1;

  logic [WIDTH-1:0] nxt;
  logic             at_max;
  logic             at_min;

  assign at_max = (Q == ONES);
  assign at_min = (Q == '0);

  always_comb begin
    nxt = Q;
    case (FunSel)
      FS_CLR:  nxt = '0;
      FS_LOAD: nxt = I;
      FS_INC:  nxt = (SATURATE && at_max) ? ONES : Q + WIDTH'(1);
      FS_DEC:  nxt = (SATURATE && at_min) ? '0 : Q - WIDTH'(1);
      FS_SHL:  nxt = {Q[WIDTH-2:0], 1'b0};
      FS_SHR:  nxt = {1'b0, Q[WIDTH-1:1]};
      FS_ROL:  nxt = {Q[WIDTH-2:0], Q[WIDTH-1]};
      default: nxt = Q;
    endcase
  end

  // The event fires in both wrap and saturate modes.
  assign OvfEvt = En && (((FunSel == FS_INC) && at_max) ||
                         ((FunSel == FS_DEC) && at_min));

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      Q <= RST_V;
    end else if (En) begin
      Q <= nxt;
    end
  end

endmodule

// File: rtl/param_regfile.sv
// Parametrised register file: NUM_REGS x WIDTH cells with a masked write/function
// path, two combinational read ports with zero flags, and a sticky overflow flag.
module param_regfile
  import regfile_pkg::*;
#(
  parameter int          WIDTH     = 8,
  parameter int          NUM_REGS  = 4,
  parameter bit          SATURATE  = 1'b0,
  parameter int unsigned RESET_VAL = 0
) (
  input  logic                        CLK,
  input  logic                        RST_N,
  input  logic                        E,
  input  logic [2:0]                  FunSel,
  input  logic [NUM_REGS-1:0]         RegSel,
  input  logic [WIDTH-1:0]            I,
  input  logic [sel_w(NUM_REGS)-1:0]  OutASel,
  input  logic [sel_w(NUM_REGS)-1:0]  OutBSel,
  output logic [WIDTH-1:0]            OutA,
  output logic [WIDTH-1:0]            OutB,
  output logic                        ZeroA,
  output logic                        ZeroB,
  input  logic                        ClrOvf,
  output logic                        Ovf
);

  logic [WIDTH-1:0]    q [NUM_REGS];
  logic [NUM_REGS-1:0] evt;

  for (genvar k = 0; k < NUM_REGS; k++) begin : g_reg
    reg_cell #(
      .WIDTH     (WIDTH),
      .SATURATE  (SATURATE),
      .RESET_VAL (RESET_VAL)
    ) u_cell (
      .CLK    (CLK),
      .RST_N  (RST_N),
      .En     (E & RegSel[k]),
      .FunSel (FunSel),
      .I      (I),
      .Q      (q[k]),
      .OvfEvt (evt[k])
    );
  end

  // A new overflow event outranks a simultaneous clear.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      Ovf <= 1'b0;
    end else if (|evt) begin
      Ovf <= 1'b1;
    end else if (ClrOvf) begin
      Ovf <= 1'b0;
    end
  end

  // Selects past the last register read as zero.
  always_comb begin
    OutA = '0;
    OutB = '0;
    for (int k = 0; k < NUM_REGS; k++) begin
      if (int'(OutASel) == k) OutA = q[k];
      if (int'(OutBSel) == k) OutB = q[k];
    end
  end

  assign ZeroA = (OutA == '0);
  assign ZeroB = (OutB == '0);

endmodule

// File: tb/tb_param_regfile.sv
// Bench for param_regfile: three builds (wrap, saturate, 3-register) share one
// stimulus stream and are compared against an arithmetic reference model.
`timescale 1ns/1ps
module tb_param_regfile;

  logic       clk;
  logic       rst_n;
  logic       e;
  logic [2:0] funsel;
  logic [3:0] regsel;
  logic [7:0] i_data;
  logic [1:0] asel;
  logic [1:0] bsel;
  logic       clrovf;

  logic [7:0] outa [3];
  logic [7:0] outb [3];
  logic       za [3];
  logic       zb [3];
  logic       ovf [3];

  int n_checks = 0;
  int n_errors = 0;

  int nregs [3] = '{4, 4, 3};
  int sat   [3] = '{0, 1, 0};
  int rv    [3] = '{'h5A, 'h33, 'h5A};
  int m     [3][4];
  int movf  [3];

  param_regfile #(.WIDTH(8), .NUM_REGS(4), .SATURATE(1'b0), .RESET_VAL(32'h5A)) dut_wrap (
    .CLK(clk), .RST_N(rst_n), .E(e), .FunSel(funsel), .RegSel(regsel), .I(i_data),
    .OutASel(asel), .OutBSel(bsel), .OutA(outa[0]), .OutB(outb[0]),
    .ZeroA(za[0]), .ZeroB(zb[0]), .ClrOvf(clrovf), .Ovf(ovf[0]));

  param_regfile #(.WIDTH(8), .NUM_REGS(4), .SATURATE(1'b1), .RESET_VAL(32'h33)) dut_sat (
    .CLK(clk), .RST_N(rst_n), .E(e), .FunSel(funsel), .RegSel(regsel), .I(i_data),
    .OutASel(asel), .OutBSel(bsel), .OutA(outa[1]), .OutB(outb[1]),
    .ZeroA(za[1]), .ZeroB(zb[1]), .ClrOvf(clrovf), .Ovf(ovf[1]));

  param_regfile #(.WIDTH(8), .NUM_REGS(3), .SATURATE(1'b0), .RESET_VAL(32'h5A)) dut_n3 (
    .CLK(clk), .RST_N(rst_n), .E(e), .FunSel(funsel), .RegSel(regsel[2:0]), .I(i_data),
    .OutASel(asel), .OutBSel(bsel), .OutA(outa[2]), .OutB(outb[2]),
    .ZeroA(za[2]), .ZeroB(zb[2]), .ClrOvf(clrovf), .Ovf(ovf[2]));

  initial clk = 1'b0;
  always #10 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog obs=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int d = 0; d < 3; d++) begin
      for (int k = 0; k < 4; k++) m[d][k] = rv[d];
      movf[d] = 0;
    end
  endtask

  // Evaluated with the inputs that were present at the rising edge.
  task automatic model_edge();
    for (int d = 0; d < 3; d++) begin
      bit ev = 0;
      if (e) begin
        for (int k = 0; k < nregs[d]; k++) begin
          if (regsel[k]) begin
            int v = m[d][k];
            int nv = v;
            case (funsel)
              3'd0: nv = 0;
              3'd1: nv = i_data;
              3'd2: if (v == 255) begin ev = 1; nv = sat[d] ? 255 : 0; end else nv = v + 1;
              3'd3: if (v == 0) begin ev = 1; nv = sat[d] ? 0 : 255; end else nv = v - 1;
              3'd4: nv = (v * 2) % 256;
              3'd5: nv = v / 2;
              3'd6: nv = (v * 2) % 256 + v / 128;
              default: nv = v;
            endcase
            m[d][k] = nv;
          end
        end
      end
      if (ev) movf[d] = 1;
      else if (clrovf) movf[d] = 0;
    end
  endtask

  task automatic check_regs();
    for (int s = 0; s < 4; s++) begin
      asel = 2'(s);
      bsel = 2'(3 - s);
      #1;
      for (int d = 0; d < 3; d++) begin
        int ea = (s < nregs[d]) ? m[d][s] : 0;
        int eb = ((3 - s) < nregs[d]) ? m[d][3 - s] : 0;
        chk($sformatf("outa_d%0d_r%0d", d, s), 32'(outa[d]), 32'(ea));
        chk($sformatf("outb_d%0d_r%0d", d, 3 - s), 32'(outb[d]), 32'(eb));
        chk($sformatf("zeroa_d%0d_r%0d", d, s), 32'(za[d]), 32'(ea == 0));
        chk($sformatf("zerob_d%0d_r%0d", d, 3 - s), 32'(zb[d]), 32'(eb == 0));
      end
    end
    for (int d = 0; d < 3; d++) chk($sformatf("ovf_d%0d", d), 32'(ovf[d]), 32'(movf[d]));
  endtask

  task automatic drive(input logic en, input logic [2:0] fs, input logic [3:0] rs,
                       input logic [7:0] data, input logic clr);
    e = en; funsel = fs; regsel = rs; i_data = data; clrovf = clr;
  endtask

  task automatic cycle();
    @(posedge clk);
    model_edge();
    #1;
    check_regs();
  endtask

  // Pulses reset between edges and checks the registers before any edge.
  task automatic async_reset();
    #1;
    rst_n = 1'b0;
    #1;
    model_reset();
    check_regs();
    rst_n = 1'b1;
    #1;
  endtask

  task automatic peek_a(input int idx, input int d, input string tag, input int exp);
    asel = 2'(idx);
    #1;
    chk(tag, 32'(outa[d]), 32'(exp));
  endtask

  initial begin
    rst_n = 1'b0;
    drive(1'b0, 3'd7, 4'h0, 8'h00, 1'b0);
    asel = 2'd0;
    bsel = 2'd0;
    model_reset();
    @(posedge clk);
    #1;
    check_regs();
    rst_n = 1'b1;

    drive(1'b1, 3'd1, 4'b1010, 8'hAA, 1'b0);
    cycle();
    peek_a(1, 0, "load_r1", 'hAA);
    peek_a(0, 0, "load_r0_held", 'h5A);

    drive(1'b1, 3'd1, 4'b0001, 8'hFF, 1'b0);
    cycle();
    drive(1'b1, 3'd2, 4'b0001, 8'h00, 1'b0);
    cycle();
    peek_a(0, 0, "wrap_r0", 'h00);
    peek_a(0, 1, "sat_r0", 'hFF);
    chk("wrap_ovf", 32'(ovf[0]), 32'd1);
    chk("sat_ovf", 32'(ovf[1]), 32'd1);

    drive(1'b1, 3'd7, 4'b0000, 8'h00, 1'b1);
    cycle();
    chk("clr_alone", 32'(ovf[0]), 32'd0);
    drive(1'b1, 3'd1, 4'b0100, 8'h00, 1'b0);
    cycle();
    drive(1'b1, 3'd3, 4'b0100, 8'h00, 1'b1);
    cycle();
    chk("set_beats_clr", 32'(ovf[0]), 32'd1);
    drive(1'b0, 3'd0, 4'b1111, 8'h00, 1'b1);
    cycle();
    chk("clr_when_e0", 32'(ovf[0]), 32'd0);

    drive(1'b1, 3'd1, 4'b0010, 8'h81, 1'b0);
    cycle();
    drive(1'b1, 3'd6, 4'b0010, 8'h00, 1'b0);
    cycle();
    peek_a(1, 0, "rol", 'h03);
    drive(1'b1, 3'd4, 4'b0010, 8'h00, 1'b0);
    cycle();
    peek_a(1, 0, "shl", 'h06);
    drive(1'b1, 3'd5, 4'b0010, 8'h00, 1'b0);
    cycle();
    peek_a(1, 0, "shr", 'h03);
    chk("shift_ovf", 32'(ovf[0]), 32'd0);

    drive(1'b0, 3'd0, 4'b1111, 8'h00, 1'b0);
    cycle();
    asel = 2'd3;
    #1;
    chk("oor_outa", 32'(outa[2]), 32'd0);
    chk("oor_zeroa", 32'(za[2]), 32'd1);
    async_reset();
    peek_a(1, 0, "reset_mid", 'h5A);

    for (int n = 0; n < 400; n++) begin
      logic [7:0] d;
      case ($urandom_range(0, 3))
        0: d = 8'h00;
        1: d = 8'hFF;
        default: d = 8'($urandom);
      endcase
      drive(($urandom_range(0, 7) != 0), 3'($urandom_range(0, 7)), 4'($urandom),
            d, ($urandom_range(0, 5) == 0));
      if ($urandom_range(0, 39) == 0) async_reset();
      else cycle();
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/param_regfile.md
Name: param_regfile

Overview:
Parametrised successor to the fixed 4x8 register file used on the datapath.
- Holds NUM_REGS registers of WIDTH bits each.
- Two independent combinational read ports, each with a zero flag.
- One write/function path that can act on any subset of registers in the same cycle.
- Adds an extended 3-bit FunSel (shift/rotate), selectable saturating or wrapping inc/dec, a sticky overflow flag, and asynchronous active-low reset.
- Sits between the ALU result bus and the ALU operand muxes.

Parameters:
- WIDTH, 8, bits per register (>=2).
- NUM_REGS, 4, number of registers (2..16).
- SATURATE, 0, 0 = inc/dec wrap; 1 = inc/dec clamp at all-ones/zero.
- RESET_VAL, 0, value loaded into every register on reset.

Ports:
- CLK  in  1  rising-edge clock.
- RST_N  in  1  asynchronous active-low reset.
- E  in  1  global enable; 0 freezes all registers (Ovf may still be cleared).
- FunSel  in  3  operation applied to selected registers.
- RegSel  in  NUM_REGS  bit k=1 selects register k (active-high mask).
- I  in  WIDTH  load data.
- OutASel  in  clog2(NUM_REGS)  read port A index.
- OutBSel  in  clog2(NUM_REGS)  read port B index.
- OutA  out  WIDTH  contents of register OutASel.
- OutB  out  WIDTH  contents of register OutBSel.
- ZeroA  out  1  OutA == 0.
- ZeroB  out  1  OutB == 0.
- ClrOvf  in  1  synchronous clear of Ovf.
- Ovf  out  1  sticky overflow/underflow flag.

Behaviour:
- Reset: RST_N=0 immediately sets all registers to RESET_VAL[WIDTH-1:0] and Ovf to 0, independent of CLK. Deassertion takes effect at the next rising edge.
- Update rule: on a rising edge with E=1, every register k with RegSel[k]=1 takes the FunSel result. Unselected registers hold. With E=0 nothing changes.
- FunSel encoding:
  - 000 clear to 0
  - 001 load I
  - 010 increment
  - 011 decrement
  - 100 logical shift left (LSB<=0)
  - 101 logical shift right (MSB<=0)
  - 110 rotate left
  - 111 hold
- Multiple selected registers: each is computed from its own current value in the same cycle. For load, all receive I.
- Wrap mode (SATURATE=0): all-ones+1 -> 0; 0-1 -> all-ones. Width is truncated to WIDTH.
- Saturate mode (SATURATE=1): all-ones+1 stays all-ones; 0-1 stays 0.
- Ovf set condition: any selected register performing inc at all-ones or dec at 0 while E=1, in either mode. Shifts never set Ovf.
- Ovf priority: ClrOvf=1 clears Ovf on the edge regardless of E. If a set condition and ClrOvf coincide, the set wins (Ovf=1).
- Reads: fully combinational from current register state, so no write-to-read bypass. A write at edge t is visible on OutA/OutB after edge t.
- Out-of-range select: OutASel/OutBSel >= NUM_REGS (non-power-of-2 NUM_REGS) drives 0 and the corresponding Zero flag = 1.
- Both read ports may select the same register.
- Latency: write 1 cycle; read 0 cycles.
- Reset mid-operation: RST_N low overrides any in-flight FunSel. No partial update survives.

Decomposition:
- Shared package regfile_pkg:
  - FunSel localparams FS_CLR, FS_LOAD, FS_INC, FS_DEC, FS_SHL, FS_SHR, FS_ROL, FS_HOLD.
  - Helper function for clog2-safe select width.
- Sub-module reg_cell, one register: parameters WIDTH, SATURATE, RESET_VAL; ports CLK, RST_N, En, FunSel, I, Q, OvfEvt.
  - Instantiated NUM_REGS times via generate.
  - The top ORs the OvfEvt outputs into the sticky flag and builds the two read muxes.

Test Plan (WIDTH=8, NUM_REGS=4 unless stated):
- Reset: RST_N=0 asynchronously between edges with RESET_VAL=8'h5A -> all of R0..R3 read 5A on both ports within the same cycle; Ovf=0.
- Multi-select load: E=1, FunSel=001, RegSel=4'b1010, I=8'hAA, 1 edge -> R1=R3=AA, R0/R2 unchanged. OutASel=1, OutBSel=3 -> both AA; ZeroA=0.
- Wrap vs saturate: R0=FF, FunSel=010, RegSel=0001 -> R0=00, Ovf=1 (SATURATE=0). With SATURATE=1 the same stimulus gives R0=FF, Ovf=1.
- Ovf priority: ClrOvf=1 alone -> Ovf=0. Then R2=00, dec with ClrOvf=1 in the same edge -> Ovf=1. With E=0 and ClrOvf=1 -> Ovf=0 and registers unchanged.
- Shifts: R1=8'b1000_0001:
  - FunSel=110 -> 0000_0011
  - then 100 -> 0000_0110
  - then 101 -> 0000_0011
  - Ovf unaffected throughout.
- Enable/out-of-range (NUM_REGS=3 build): E=0, FunSel=000, RegSel=all ones -> no change. OutASel=3 -> OutA=0, ZeroA=1. RST_N pulsed mid-sequence -> immediate return to RESET_VAL.
